serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first.
// Result, carry-out and signed overflow appear with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic bit_sum;
    logic carry_nx;
    logic last;
    logic accept;

    assign bit_sum  = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last     = (cnt == LAST);
    assign accept   = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status flags are registered copies of the next state, so they
    // track the state register exactly without decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= carry_nx;
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

    // Sum shifts in from the top so the LSB lands at bit 0 after
    // WIDTH steps; the old result stays visible until the first step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            sum <= {bit_sum, sum[WIDTH-1:1]};
            if (last) begin
                c_out    <= carry_nx;
                overflow <= carry ^ carry_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks for serial_adder at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic vc,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int cyc;
        a = va;
        b = vb;
        c_in = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            check({tag, "_nodone"}, done, 0);
            cyc++;
            tick();
        end
        check({tag, "_busycyc"}, cyc, W);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        tick();
        check({tag, "_done1"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int pulses;
        int t1;
        int t2;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic c2;

        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", overflow, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("add3_5", 8'd3, 8'd5, 1'b0, 8'd8, 1'b0, 1'b0);
        run_op("wrap", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
        run_op("sovf", 8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
        repeat (3) tick();
        check("hold_sum", sum, 128);
        check("hold_ovf", overflow, 1);
        run_op("cin", 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);

        // start pulse in the 4th RUN cycle must be ignored
        a = 8'd3;
        b = 8'd5;
        c_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        s1 = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                pulses++;
                s1 = sum;
            end
            tick();
        end
        check("ign_pulses", pulses, 1);
        check("ign_sum", s1, 8);

        // async reset in the 5th RUN cycle
        a = 8'd100;
        b = 8'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy", busy, 1);
        check("mid_partial", sum, 8'h60);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sum", sum, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) pulses++;
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        check("arst_nodone", pulses, 0);
        run_op("post_rst", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

        // back-to-back with start held high
        a = 8'd20;
        b = 8'd22;
        c_in = 1'b0;
        start = 1'b1;
        tick();
        a = 8'd200;
        b = 8'd100;
        c_in = 1'b1;
        pulses = 0;
        t1 = 0;
        t2 = 0;
        s1 = '0;
        s2 = '0;
        c2 = 1'b0;
        for (int i = 1; i <= 40 && pulses < 2; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    t1 = i;
                    s1 = sum;
                end else begin
                    t2 = i;
                    s2 = sum;
                    c2 = c_out;
                    start = 1'b0;
                end
            end
            if (pulses < 2) tick();
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_period", t2 - t1, W + 2);
        check("b2b_sum1", s1, 42);
        check("b2b_sum2", s2, 45);
        check("b2b_cout2", c2, 1);
        repeat (3) tick();
        check("b2b_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
